// File: rtl/display_pkg.sv
// Shared types, constants and the round-robin pick helper for display_arbiter.
package display_pkg;

    typedef logic [15:0] disp_word_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_t;

    localparam logic [3:0] BLANK_CODE = 4'hF;
    localparam int         MAX_REQ    = 8;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } rr_pick_t;

    // Searches ptr+1, ptr+2, ... modulo num_req and returns the first valid index.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                         input logic [2:0]         ptr,
                                         input int                 num_req);
        rr_pick_t pick;
        int       cand;
        pick = '0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            cand = (int'(ptr) + k) % num_req;
            if ((k <= num_req) && !pick.found && valid[cand[2:0]]) begin
                pick.found = 1'b1;
                pick.idx   = cand[2:0];
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first valid requester after ptr wins.
module rr_arbiter
    import display_pkg::*;
#(
    parameter  int NUM_REQ = 3,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               found
);

    logic [MAX_REQ-1:0] valid_ext;
    logic [2:0]         ptr_ext;
    rr_pick_t           pick;

    assign valid_ext = MAX_REQ'(valid);
    assign ptr_ext   = 3'(ptr);
    assign pick      = rr_pick(valid_ext, ptr_ext, NUM_REQ);
    assign found     = pick.found;
    assign grant_idx = IDX_W'(pick.idx);

endmodule

// File: rtl/display_arbiter.sv
// Round-robin sharing of the 16-bit display word with minimum hold time and requester-0 preemption.
// Optional idle blanking is enabled with `define DISPLAY_ARBITER_IDLE_BLANK_EN.
module display_arbiter
    import display_pkg::*;
#(
    parameter  int          NUM_REQ     = 3,
    parameter  int          HOLD_CYCLES = 50_000_000,
    parameter  int          IDLE_CYCLES = 500_000_000,
    parameter  logic [15:0] BLANK_WORD  = {4{BLANK_CODE}},
    localparam int          IDX_W       = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [16*NUM_REQ-1:0]  req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [15:0]            display_word,
    output logic                   display_valid,
    output logic [IDX_W-1:0]       display_src,
    output logic                   hold_busy
);

    localparam int               TMR_W      = $clog2(HOLD_CYCLES);
    localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [0:0]       ST_IDLE    = IDLE;
    localparam logic [0:0]       ST_HOLD    = HOLD;

    logic [0:0]       state;
    logic [TMR_W-1:0] timer;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] rr_idx;
    logic [IDX_W-1:0] grant_idx;
    logic             rr_found;
    logic             can_rotate;
    logic             preempt;
    logic             grant;
    logic             blank_now;
    disp_word_t       grant_word;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .valid     (req_valid),
        .ptr       (rr_ptr),
        .grant_idx (rr_idx),
        .found     (rr_found)
    );

    // Round-robin may run when idle or on the last hold cycle; otherwise only requester 0 can cut in.
    assign can_rotate = (state == ST_IDLE) || (timer == '0);
    assign preempt    = (state == ST_HOLD) && (timer != '0) && (display_src != '0) && req_valid[0];
    assign grant      = !reset && (preempt || (can_rotate && rr_found));
    assign grant_idx  = preempt ? '0 : rr_idx;
    assign grant_word = req_data[{grant_idx, 4'b0000} +: 16];
    assign req_ready  = grant ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx) : '0;
    assign hold_busy  = (state == ST_HOLD);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            timer         <= '0;
            rr_ptr        <= IDX_W'(NUM_REQ - 1);
            display_word  <= '0;
            display_valid <= 1'b0;
            display_src   <= '0;
        end else if (grant) begin
            state         <= ST_HOLD;
            timer         <= TMR_RELOAD;
            display_word  <= grant_word;
            display_valid <= 1'b1;
            display_src   <= grant_idx;
            if (!preempt) begin
                rr_ptr <= grant_idx;
            end
        end else if (state == ST_HOLD) begin
            if (timer == '0) begin
                state <= ST_IDLE;
            end else begin
                timer <= timer - 1'b1;
            end
        end else if (blank_now) begin
            display_word  <= BLANK_WORD;
            display_valid <= 1'b0;
        end
    end

`ifdef DISPLAY_ARBITER_IDLE_BLANK_EN
    localparam int               IDLE_W    = $clog2(IDLE_CYCLES);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);

    logic [IDLE_W-1:0] idle_cnt;

    assign blank_now = (state == ST_IDLE) && !grant && (idle_cnt == IDLE_LAST);

    // Saturates at the last count so the display stays blank until the next grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_cnt <= '0;
        end else if (grant) begin
            idle_cnt <= '0;
        end else if ((state == ST_IDLE) && (idle_cnt != IDLE_LAST)) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    logic [31:0] unused_idle_cycles;

    assign blank_now          = 1'b0;
    assign unused_idle_cycles = IDLE_CYCLES;
`endif

endmodule
